// File: rtl/level_crossing_gate_ctrl_if.sv
// rtl/level_crossing_gate_ctrl_if.sv - road-side I/O bundle of the level crossing gate controller
interface level_crossing_gate_ctrl_if #(
  parameter int OCC_W = 6
);
  logic             enter;
  logic             leave;
  logic             gate_up_sw;
  logic             gate_down_sw;
  logic             motor_down;
  logic             motor_up;
  logic             lamp;
  logic             buzzer;
  logic             gate_closed;
  logic             fault;
  logic             count_err;
  logic [OCC_W-1:0] occupancy;
  logic [2:0]       state;

  modport master (
    output enter, leave, gate_up_sw, gate_down_sw,
    input  motor_down, motor_up, lamp, buzzer, gate_closed, fault, count_err, occupancy, state
  );

  modport slave (
    input  enter, leave, gate_up_sw, gate_down_sw,
    output motor_down, motor_up, lamp, buzzer, gate_closed, fault, count_err, occupancy, state
  );
endinterface

// File: rtl/level_crossing_gate_ctrl.sv
// rtl/level_crossing_gate_ctrl.sv - barrier, lamp and buzzer sequencer for an automatic level crossing
module level_crossing_gate_ctrl #(
  parameter int WARN_CYCLES  = 8,
  parameter int CLEAR_CYCLES = 4,
  parameter int MOVE_TIMEOUT = 20,
  parameter int FLASH_HALF   = 2,
  parameter int OCC_W        = 6
) (
  input  logic                     Clk,
  input  logic                     Reset,
  level_crossing_gate_ctrl_if.slave io
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WARN   = 3'd1,
    S_LOWER  = 3'd2,
    S_CLOSED = 3'd3,
    S_HOLD   = 3'd4,
    S_RAISE  = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  localparam logic [15:0]      WARN_LAST  = 16'(WARN_CYCLES - 1);
  localparam logic [15:0]      CLEAR_LAST = 16'(CLEAR_CYCLES - 1);
  localparam logic [15:0]      MOVE_LAST  = 16'(MOVE_TIMEOUT - 1);
  localparam logic [15:0]      FLASH_LAST = 16'(FLASH_HALF - 1);
  localparam logic [OCC_W-1:0] OCC_MAX    = '1;

  state_t           cur;
  state_t           next;
  logic [15:0]      timer;
  logic [15:0]      flash_cnt;
  logic             flash_on;
  logic [OCC_W-1:0] occ;
  logic             cnt_err;
  logic             occupied;
  logic             timing;
  logic             flashing;

  assign occupied = (occ != '0);
  assign timing   = (cur == S_WARN) || (cur == S_LOWER) || (cur == S_HOLD) || (cur == S_RAISE);
  assign flashing = (cur == S_WARN) || (cur == S_LOWER) || (cur == S_CLOSED) ||
                    (cur == S_HOLD) || (cur == S_RAISE);

  // Saturating occupancy; a simultaneous enter and leave cancel out.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      occ     <= '0;
      cnt_err <= 1'b0;
    end else if (io.enter && !io.leave) begin
      if (occ == OCC_MAX) cnt_err <= 1'b1;
      else                occ     <= occ + 1'b1;
    end else if (io.leave && !io.enter) begin
      if (occ == '0) cnt_err <= 1'b1;
      else           occ     <= occ - 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) cur <= S_IDLE;
    else       cur <= next;
  end

  always_comb begin
    next = cur;
    if (cur != S_FAULT && io.gate_up_sw && io.gate_down_sw) begin
      next = S_FAULT;
    end else begin
      case (cur)
        S_IDLE:   if (occupied) next = S_WARN;
        S_WARN:   if (timer == WARN_LAST) next = S_LOWER;
        S_LOWER: begin
          if (io.gate_down_sw)         next = S_CLOSED;
          else if (timer == MOVE_LAST) next = S_FAULT;
        end
        S_CLOSED: begin
          if (!io.gate_down_sw) next = S_FAULT;
          else if (!occupied)   next = S_HOLD;
        end
        S_HOLD: begin
          if (!io.gate_down_sw)         next = S_FAULT;
          else if (occupied)            next = S_CLOSED;
          else if (timer == CLEAR_LAST) next = S_RAISE;
        end
        S_RAISE: begin
          // A train arriving while the barrier is going up sends it straight back down.
          if (occupied)                next = S_LOWER;
          else if (io.gate_up_sw)      next = S_IDLE;
          else if (timer == MOVE_LAST) next = S_FAULT;
        end
        S_FAULT:  next = S_FAULT;
        default:  next = S_FAULT;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)            timer <= '0;
    else if (next != cur) timer <= '0;
    else if (timing)      timer <= timer + 16'd1;
  end

  // Flash phase is set at the start of each warning and runs on through the whole cycle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      flash_cnt <= '0;
      flash_on  <= 1'b0;
    end else if (cur == S_IDLE && next == S_WARN) begin
      flash_cnt <= '0;
      flash_on  <= 1'b1;
    end else if (flashing) begin
      if (flash_cnt == FLASH_LAST) begin
        flash_cnt <= '0;
        flash_on  <= ~flash_on;
      end else begin
        flash_cnt <= flash_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    io.motor_down  = 1'b0;
    io.motor_up    = 1'b0;
    io.buzzer      = 1'b0;
    io.lamp        = 1'b0;
    io.gate_closed = 1'b0;
    io.fault       = 1'b0;
    io.state       = cur;
    io.occupancy   = occ;
    io.count_err   = cnt_err;
    case (cur)
      S_WARN: begin
        io.buzzer = 1'b1;
        io.lamp   = flash_on;
      end
      S_LOWER: begin
        io.motor_down = 1'b1;
        io.buzzer     = 1'b1;
        io.lamp       = flash_on;
      end
      S_CLOSED, S_HOLD: begin
        io.gate_closed = 1'b1;
        io.lamp        = flash_on;
      end
      S_RAISE: begin
        io.motor_up = 1'b1;
        io.lamp     = flash_on;
      end
      S_FAULT: begin
        io.fault  = 1'b1;
        io.buzzer = 1'b1;
        io.lamp   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_level_crossing_gate_ctrl.sv
// tb/tb_level_crossing_gate_ctrl.sv - directed and randomized check of level_crossing_gate_ctrl against a reference model
module tb_level_crossing_gate_ctrl;
  localparam int WARN_CYCLES  = 8;
  localparam int CLEAR_CYCLES = 4;
  localparam int MOVE_TIMEOUT = 20;
  localparam int FLASH_HALF   = 2;
  localparam int OCC_W        = 6;
  localparam int OCC_MAX      = (1 << OCC_W) - 1;

  localparam int IDLE = 0, WARN = 1, LOWER = 2, CLOSED = 3, HOLD = 4, RAISE = 5, FAULT = 6;

  logic Clk = 1'b0;
  logic Reset = 1'b1;

  level_crossing_gate_ctrl_if #(.OCC_W(OCC_W)) bus ();

  level_crossing_gate_ctrl #(
    .WARN_CYCLES(WARN_CYCLES), .CLEAR_CYCLES(CLEAR_CYCLES), .MOVE_TIMEOUT(MOVE_TIMEOUT),
    .FLASH_HALF(FLASH_HALF), .OCC_W(OCC_W)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .io(bus)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;
  // model: state code, cycles spent in the state, cycles since the warning began
  int m_state, m_occ, m_err, m_dwell, m_flash;
  int pos, travel, warn_n, n, r;
  logic [7:0] lamp_seq;
  logic arriving;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = IDLE; m_occ = 0; m_err = 0; m_dwell = 0; m_flash = 0;
  endtask

  task automatic model_step(input logic en, input logic lv, input logic up, input logic dn);
    int ns;
    int occ_n;
    occ_n = m_occ;
    if (en && !lv) begin
      if (m_occ == OCC_MAX) m_err = 1; else occ_n = m_occ + 1;
    end else if (lv && !en) begin
      if (m_occ == 0) m_err = 1; else occ_n = m_occ - 1;
    end
    ns = m_state;
    if (m_state != FAULT && up && dn) ns = FAULT;
    else case (m_state)
      IDLE:   if (m_occ != 0) ns = WARN;
      WARN:   if (m_dwell == WARN_CYCLES - 1) ns = LOWER;
      LOWER:  if (dn) ns = CLOSED; else if (m_dwell == MOVE_TIMEOUT - 1) ns = FAULT;
      CLOSED: if (!dn) ns = FAULT; else if (m_occ == 0) ns = HOLD;
      HOLD:   if (!dn) ns = FAULT; else if (m_occ != 0) ns = CLOSED;
              else if (m_dwell == CLEAR_CYCLES - 1) ns = RAISE;
      RAISE:  if (m_occ != 0) ns = LOWER; else if (up) ns = IDLE;
              else if (m_dwell == MOVE_TIMEOUT - 1) ns = FAULT;
      default: ns = FAULT;
    endcase
    m_flash = (m_state == IDLE && ns == WARN) ? 0 : m_flash + 1;
    m_dwell = (ns != m_state) ? 0 : m_dwell + 1;
    m_state = ns;
    m_occ   = occ_n;
  endtask

  function automatic logic exp_lamp();
    if (m_state >= WARN && m_state <= RAISE) return ((m_flash / FLASH_HALF) % 2) == 0;
    return m_state == FAULT;
  endfunction

  task automatic check_all();
    check("state",       bus.state,       m_state);
    check("occupancy",   bus.occupancy,   m_occ);
    check("count_err",   bus.count_err,   m_err);
    check("motor_down",  bus.motor_down,  m_state == LOWER);
    check("motor_up",    bus.motor_up,    m_state == RAISE);
    check("buzzer",      bus.buzzer,      m_state == WARN || m_state == LOWER || m_state == FAULT);
    check("lamp",        bus.lamp,        exp_lamp());
    check("gate_closed", bus.gate_closed, m_state == CLOSED || m_state == HOLD);
    check("fault",       bus.fault,       m_state == FAULT);
  endtask

  task automatic tick();
    @(posedge Clk);
    model_step(bus.enter, bus.leave, bus.gate_up_sw, bus.gate_down_sw);
    #1;
    check_all();
  endtask

  // Entered just after an edge; the extra delay lets reset land mid-cycle.
  task automatic do_reset(input int delay);
    bus.enter = 0; bus.leave = 0;
    #(delay);
    Reset = 1;
    #1;
    model_reset();
    check_all();
    @(posedge Clk);
    #1;
    Reset = 0;
  endtask

  task automatic run_to_closed();
    bus.enter = 1; tick(); bus.enter = 0;
    for (int k = 0; k < 50 && m_state != LOWER; k++) tick();
    bus.gate_up_sw = 0;
    repeat (2) tick();
    bus.gate_down_sw = 1;
    tick();
    check("reach_closed", bus.state, CLOSED);
  endtask

  initial begin
    bus.enter = 0; bus.leave = 0; bus.gate_up_sw = 1; bus.gate_down_sw = 0;
    model_reset();
    @(posedge Clk);
    #1;
    check_all();
    check("rst_occupancy", bus.occupancy, 0);
    check("rst_lamp", bus.lamp, 0);
    Reset = 0;

    // basic crossing with lamp waveform
    warn_n = 0; lamp_seq = '0;
    for (int i = 0; i < 12; i++) begin
      bus.enter = (i < 4);
      tick();
      if (i == 1) check("warn_after_2", bus.state, WARN);
      if (i == 9) check("motor_down_on", bus.motor_down, 1);
      if (bus.state == WARN) begin
        warn_n++;
        lamp_seq = {lamp_seq[6:0], bus.lamp};
      end
      if (m_state == LOWER) bus.gate_up_sw = 0;
    end
    bus.enter = 0;
    check("warn_len", warn_n, WARN_CYCLES);
    check("lamp_wave", lamp_seq, 8'b1100_1100);
    repeat (2) tick();
    bus.gate_down_sw = 1;
    tick();
    check("closed_state", bus.state, CLOSED);
    check("closed_flag", bus.gate_closed, 1);
    check("closed_motor", bus.motor_down, 0);
    check("occ4", bus.occupancy, 4);
    bus.leave = 1; repeat (4) tick(); bus.leave = 0;
    tick();
    check("hold_state", bus.state, HOLD);
    repeat (3) tick();
    check("hold_len", bus.state, HOLD);
    tick();
    check("raise_state", bus.state, RAISE);
    bus.gate_down_sw = 0;
    repeat (2) tick();
    bus.gate_up_sw = 1;
    tick();
    check("idle_state", bus.state, IDLE);
    check("idle_lamp", bus.lamp, 0);
    check("idle_buzzer", bus.buzzer, 0);

    // reversal in HOLD and in RAISE
    run_to_closed();
    bus.leave = 1; tick(); bus.leave = 0;
    tick();
    check("rev_hold", bus.state, HOLD);
    repeat (2) tick();
    bus.enter = 1; tick(); bus.enter = 0;
    tick();
    check("rev_closed", bus.state, CLOSED);
    bus.leave = 1; tick(); bus.leave = 0;
    tick();
    repeat (3) tick();
    check("rev_hold_full", bus.state, HOLD);
    tick();
    check("rev_raise", bus.state, RAISE);
    bus.gate_down_sw = 0;
    tick();
    bus.enter = 1; tick(); bus.enter = 0;
    tick();
    check("rev_lower", bus.state, LOWER);
    check("rev_motor_up", bus.motor_up, 0);
    check("rev_motor_down", bus.motor_down, 1);

    // lowering timeout
    n = 1;
    for (int k = 0; k < 40 && bus.state !== 3'd6; k++) begin
      tick();
      if (bus.motor_down === 1'b1) n++;
    end
    check("timeout_len", n, MOVE_TIMEOUT);
    check("timeout_state", bus.state, FAULT);
    check("timeout_lamp", bus.lamp, 1);
    check("timeout_motors", {bus.motor_up, bus.motor_down}, 2'b00);
    repeat (5) tick();
    check("fault_sticky", bus.fault, 1);
    do_reset(0);

    // sensor faults
    bus.gate_up_sw = 1; bus.gate_down_sw = 1;
    tick();
    check("both_sw_fault", bus.state, FAULT);
    bus.gate_down_sw = 0;
    do_reset(0);
    run_to_closed();
    bus.gate_down_sw = 0;
    tick();
    check("down_drop_fault", bus.state, FAULT);
    bus.gate_up_sw = 1;
    do_reset(0);

    // occupancy edge cases and async reset mid-LOWER
    bus.leave = 1; tick(); bus.leave = 0;
    check("underflow_err", bus.count_err, 1);
    check("underflow_occ", bus.occupancy, 0);
    do_reset(0);
    bus.enter = 1; repeat (3) tick();
    bus.leave = 1; tick();
    bus.enter = 0; bus.leave = 0;
    check("enter_leave_occ", bus.occupancy, 3);
    for (int k = 0; k < 50 && m_state != LOWER; k++) tick();
    repeat (2) tick();
    do_reset(3);
    check("async_rst_motor", bus.motor_down, 0);
    check("async_rst_occ", bus.occupancy, 0);
    bus.enter = 1; repeat (OCC_MAX + 1) tick(); bus.enter = 0;
    check("overflow_occ", bus.occupancy, OCC_MAX);
    check("overflow_err", bus.count_err, 1);
    do_reset(0);

    // randomized traffic against a simple barrier plant
    for (int ep = 0; ep < 6; ep++) begin
      travel = $urandom_range(2, 24);
      pos = 0;
      bus.gate_up_sw = 1; bus.gate_down_sw = 0;
      do_reset(0);
      for (int c = 0; c < 300; c++) begin
        arriving = ((c / 40) % 2) == 0;
        r = $urandom_range(0, 99);
        bus.enter = arriving ? (r < 25) : (r < 3);
        r = $urandom_range(0, 99);
        bus.leave = arriving ? (r < 6) : (r < 35);
        if (m_state == LOWER && pos < travel) pos++;
        else if (m_state == RAISE && pos > 0) pos--;
        bus.gate_down_sw = (pos >= travel);
        bus.gate_up_sw   = (pos == 0);
        r = $urandom_range(0, 999);
        if (r < 4) begin
          bus.gate_up_sw = 1; bus.gate_down_sw = 1;
        end else if (r < 8) begin
          bus.gate_down_sw = 0;
        end
        tick();
        if (m_state == FAULT && $urandom_range(0, 9) == 0) do_reset($urandom_range(0, 3));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/level_crossing_gate_ctrl.md
# level_crossing_gate_ctrl

- Sequences the road barrier, warning lamps and buzzer of the automatic level crossing.
- Maintains a bogey-occupancy count of the protected track section from single-cycle enter/leave pulses. Upstream glue derives these pulses from the bogey counters at the section boundaries.
- Drives the gate motor through a warn / lower / hold / raise cycle, supervised by the limit switches.
- Latches a fault on any timeout or sensor inconsistency.

## Interface
- WARN_CYCLES, default 8: cycles the lamps and buzzer run before lowering starts.
- CLEAR_CYCLES, default 4: cycles the section must stay empty before raising starts.
- MOVE_TIMEOUT, default 20: maximum cycles allowed for a lower or raise motion.
- FLASH_HALF, default 2: half-period of the lamp flash, in cycles.
- OCC_W, default 6: width of the occupancy counter.
- All cycle parameters are ≥1 and <2^16.
- Clk  in  1  clock.
- Reset  in  1  asynchronous, active-high.
- enter  in  1  one-cycle pulse: a bogey has entered the section.
- leave  in  1  one-cycle pulse: a bogey has left the section.
- gate_up_sw  in  1  limit switch, high when the barrier is fully raised.
- gate_down_sw  in  1  limit switch, high when the barrier is fully lowered.
- motor_down  out  1  drive the barrier down.
- motor_up  out  1  drive the barrier up.
- lamp  out  1  warning lamp.
- buzzer  out  1  audible warning.
- gate_closed  out  1  barrier confirmed down (state CLOSED or HOLD).
- fault  out  1  sticky fault; cleared only by Reset.
- count_err  out  1  sticky occupancy over/underflow; cleared only by Reset.
- occupancy  out  OCC_W  bogeys currently in the section.
- state  out  3  FSM state code.

## Operation
- **Reset values:** every output is 0. Internal state is IDLE; timer and flash counter are 0.
- **Occupancy:**
  - enter alone increments; leave alone decrements; both together leaves the count unchanged.
  - An increment at 2^OCC_W−1 or a decrement at 0 leaves the count unchanged and sets count_err.
- **State codes:** IDLE=0, WARN=1, LOWER=2, CLOSED=3, HOLD=4, RAISE=5, FAULT=6.
- **Timer:** a 16-bit timer is cleared on every state change and increments each cycle in WARN, LOWER, HOLD and RAISE.
- **Transitions** (evaluated on registered occupancy and sampled switches):
  - IDLE: occupancy≠0 → WARN.
  - WARN: timer==WARN_CYCLES−1 → LOWER. The sequence completes even if occupancy returns to 0.
  - LOWER:
    - gate_down_sw → CLOSED.
    - Otherwise timer==MOVE_TIMEOUT−1 → FAULT.
  - CLOSED:
    - gate_down_sw low → FAULT.
    - Otherwise occupancy==0 → HOLD.
  - HOLD:
    - gate_down_sw low → FAULT.
    - occupancy≠0 → CLOSED.
    - timer==CLEAR_CYCLES−1 → RAISE.
  - RAISE:
    - occupancy≠0 → LOWER (new train; timer restarts).
    - Else gate_up_sw → IDLE.
    - Else timer==MOVE_TIMEOUT−1 → FAULT.
  - FAULT: terminal until Reset.
  - Any state except FAULT: gate_up_sw and gate_down_sw both high → FAULT. This check has highest priority.
- **Outputs** (Moore, decoded from registered state and counters only; no input-to-output combinational path):
  - motor_down = LOWER.
  - motor_up = RAISE.
  - buzzer = WARN or LOWER, and also FAULT.
  - lamp:
    - Flashes in WARN through RAISE.
    - The flash counter starts on the IDLE→WARN edge with lamp=1 and toggles lamp every FLASH_HALF cycles.
    - Steady 1 in FAULT; 0 in IDLE.
  - fault = FAULT.
  - Both motors are never high together, and both are 0 in FAULT.

## Timing
- An enter pulse sampled at edge k gives occupancy=1 after edge k and state=WARN after edge k+1.
- WARN lasts exactly WARN_CYCLES cycles; HOLD lasts exactly CLEAR_CYCLES cycles if undisturbed.
- A switch sampled high at edge m moves the FSM to its new state after edge m; the motor output drops in the same cycle.
- A motion with no switch response: motor high for exactly MOVE_TIMEOUT cycles, then FAULT.
- Reset mid-operation: all outputs go to 0 immediately (asynchronously), including occupancy. The barrier position is re-learned only through the next cycle.

## Test plan
- **Basic crossing** (defaults): 4 enter pulses → WARN after 2 cycles; 8 cycles later motor_down=1. Raise gate_down_sw at cycle 5 of LOWER → CLOSED with gate_closed=1. 4 leave pulses → HOLD → RAISE after 4 cycles. gate_up_sw → IDLE with all outputs 0.
- **Lamp waveform:** in WARN, lamp reads 1,1,0,0,1,1,0,0 over 8 cycles; buzzer stays 1 throughout.
- **Reversal:** in HOLD, an enter pulse → CLOSED and the timer clears. In RAISE, an enter pulse → LOWER, motor_up→0 and motor_down→1 on the same edge.
- **Timeout:** LOWER with gate_down_sw held low → motor_down high for 20 cycles, then state=6, fault=1, lamp=1, motors 0. Fault persists until Reset.
- **Sensor faults:**
  - Both switches high in IDLE → FAULT on the next edge.
  - gate_down_sw dropping in CLOSED → FAULT.
- **Count edge cases:**
  - leave at occupancy 0 → count_err=1, occupancy stays 0.
  - Simultaneous enter+leave at occupancy 3 → stays 3.
  - Async Reset asserted mid-LOWER → all outputs 0 without waiting for a clock edge.
